// File: rtl/axis_cmd_pkg.sv
// Shared header layout, FSM encoding and defaults for the AXIS command framer.
// Header word: [31:24] magic, [23:16] opcode, [15:0] payload length in words.
package axis_cmd_pkg;

  localparam int MAGIC_MSB = 31;
  localparam int MAGIC_LSB = 24;
  localparam int OP_MSB    = 23;
  localparam int OP_LSB    = 16;
  localparam int LEN_MSB   = 15;
  localparam int LEN_LSB   = 0;

  localparam logic [7:0]  DEF_MAGIC   = 8'hA5;
  localparam logic [15:0] DEF_MAX_LEN = 16'd4096;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CMD     = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

endpackage

// File: rtl/axis_reg_slice.sv
// One-deep AXIS register slice carrying data and last; 1-cycle latency.
// Accepts a new word when empty or when the held word leaves in the same cycle.
module axis_reg_slice #(
  parameter int W = 32
) (
  input  logic         aclk,
  input  logic         resetn,
  input  logic         s_vld,
  output logic         s_rdy,
  input  logic [W-1:0] s_dat,
  input  logic         s_last,
  output logic         m_vld,
  input  logic         m_rdy,
  output logic [W-1:0] m_dat,
  output logic         m_last
);

  assign s_rdy = !m_vld || m_rdy;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      m_vld  <= 1'b0;
      m_dat  <= '0;
      m_last <= 1'b0;
    end else if (s_vld && s_rdy) begin
      m_vld  <= 1'b1;
      m_dat  <= s_dat;
      m_last <= s_last;
    end else if (m_rdy) begin
      m_vld  <= 1'b0;
      m_last <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_cmd_framer.sv
// Splits an unframed word stream into a command side channel and a tlast-framed payload.
// Payload latency 1 cycle; upstream ready only ever follows downstream ready via the slice.
module axis_cmd_framer
  import axis_cmd_pkg::*;
#(
  parameter logic [7:0]  MAGIC   = DEF_MAGIC,
  parameter logic [15:0] MAX_LEN = DEF_MAX_LEN,
  parameter int          ERR_W   = 8
) (
  input  logic             aclk,
  input  logic             resetn,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [31:0]      s_axis_tdata,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [7:0]       cmd_op,
  output logic [15:0]      cmd_len,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [31:0]      m_axis_tdata,
  output logic             busy,
  output logic [ERR_W-1:0] err_count
);

  state_t             state_q, state_d;
  logic [15:0]        remaining_q, remaining_d;
  logic               hunt_rdy_q;
  logic               cmd_valid_d;
  logic [7:0]         cmd_op_d;
  logic [15:0]        cmd_len_d;
  logic [ERR_W-1:0]   err_count_d;

  logic [7:0]  hdr_magic;
  logic [7:0]  hdr_op;
  logic [15:0] hdr_len;
  logic        hdr_bad;
  logic        in_hs;
  logic        pay_open;
  logic        slice_vld;
  logic        slice_rdy;
  logic        out_hs;

  assign hdr_magic = s_axis_tdata[MAGIC_MSB:MAGIC_LSB];
  assign hdr_op    = s_axis_tdata[OP_MSB:OP_LSB];
  assign hdr_len   = s_axis_tdata[LEN_MSB:LEN_LSB];
  assign hdr_bad   = (hdr_magic != MAGIC) || (hdr_len > MAX_LEN);

  // In HUNT ready is a plain register; in PAYLOAD it is the slice's ready term.
  assign pay_open      = (state_q == PAYLOAD) && (remaining_q != 16'd0);
  assign slice_vld     = s_axis_tvalid && pay_open;
  assign s_axis_tready = hunt_rdy_q || (pay_open && slice_rdy);
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign out_hs        = m_axis_tvalid && m_axis_tready;
  assign busy          = (state_q != HUNT) || m_axis_tvalid;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cmd_valid_d = cmd_valid;
    cmd_op_d    = cmd_op;
    cmd_len_d   = cmd_len;
    err_count_d = err_count;
    case (state_q)
      HUNT: begin
        if (in_hs) begin
          if (hdr_bad) begin
            if (err_count != '1) err_count_d = err_count + ERR_W'(1);
          end else begin
            cmd_op_d    = hdr_op;
            cmd_len_d   = hdr_len;
            remaining_d = hdr_len;
            cmd_valid_d = 1'b1;
            state_d     = CMD;
          end
        end
      end
      CMD: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = (cmd_len == 16'd0) ? HUNT : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (slice_vld && slice_rdy) remaining_d = remaining_q - 16'd1;
        if (out_hs && m_axis_tlast && (remaining_q == 16'd0)) state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= HUNT;
      remaining_q <= '0;
      hunt_rdy_q  <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_op      <= '0;
      cmd_len     <= '0;
      err_count   <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      hunt_rdy_q  <= (state_d == HUNT);
      cmd_valid   <= cmd_valid_d;
      cmd_op      <= cmd_op_d;
      cmd_len     <= cmd_len_d;
      err_count   <= err_count_d;
    end
  end

  axis_reg_slice #(.W(32)) u_payload_slice (
    .aclk   (aclk),
    .resetn (resetn),
    .s_vld  (slice_vld),
    .s_rdy  (slice_rdy),
    .s_dat  (s_axis_tdata),
    .s_last (remaining_q == 16'd1),
    .m_vld  (m_axis_tvalid),
    .m_rdy  (m_axis_tready),
    .m_dat  (m_axis_tdata),
    .m_last (m_axis_tlast)
  );

endmodule

// File: tb/tb_axis_cmd_framer.sv
// Bench for axis_cmd_framer: directed timing scenarios plus randomized streams
// checked against a word-stream parsing model.
module tb_axis_cmd_framer;

  logic        aclk = 1'b0;
  logic        resetn = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata = '0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [7:0]  cmd_op;
  logic [15:0] cmd_len;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic [31:0] m_axis_tdata;
  logic        busy;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] in_q[$];
  logic [23:0] exp_cmd[$];
  logic [23:0] obs_cmd[$];
  logic [32:0] exp_dat[$];
  logic [32:0] obs_dat[$];
  int          model_err = 0;
  int          stall_viol;
  bit          timed_out;

  always #5 aclk = ~aclk;

  axis_cmd_framer dut (
    .aclk          (aclk),
    .resetn        (resetn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_len       (cmd_len),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .busy          (busy),
    .err_count     (err_count)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic add_cmd(input logic [7:0] op, input int len);
    in_q.push_back({8'hA5, op, 16'(len)});
    for (int k = 0; k < len; k++) in_q.push_back($urandom);
  endtask

  task automatic add_bad();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(1) == 0) begin
      if (w[31:24] == 8'hA5) w[31:24] = 8'h5A;
    end else begin
      w[31:24] = 8'hA5;
      w[15:0]  = 16'($urandom_range(65535, 4097));
    end
    in_q.push_back(w);
  endtask

  // Reference: walk the word stream; a good header claims the next len words as payload.
  task automatic model_from_q();
    int i;
    logic [31:0] h;
    int len;
    exp_cmd.delete();
    exp_dat.delete();
    i = 0;
    while (i < in_q.size()) begin
      h = in_q[i];
      i++;
      len = int'(h[15:0]);
      if (h[31:24] != 8'hA5 || len > 4096) begin
        model_err++;
      end else begin
        exp_cmd.push_back(h[23:0]);
        for (int k = 0; k < len; k++) begin
          exp_dat.push_back({(k == len - 1), in_q[i]});
          i++;
        end
      end
    end
  endtask

  // Drives in_q into the DUT and records every handshake on both output channels.
  // m_mode: 0 = always ready, 1 = ready pattern 1,0,0,1, 2 = random.
  task automatic run_stream(input int m_mode, input int s_gap, input int stop_after_out);
    int cyc;
    int budget;
    bit prev_stall;
    logic [32:0] prev_out;
    bit hs_s;
    cyc = 0;
    budget = 10 * in_q.size() + 100;
    prev_stall = 0;
    prev_out = '0;
    obs_cmd.delete();
    obs_dat.delete();
    stall_viol = 0;
    timed_out = 0;
    while (1) begin
      if (prev_stall && (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} !== prev_out))
        stall_viol++;
      if (stop_after_out > 0 && obs_dat.size() >= stop_after_out) break;
      if (stop_after_out == 0 && in_q.size() == 0 && !busy && !cmd_valid) break;
      if (cyc >= budget) begin
        timed_out = 1;
        break;
      end
      if (!s_axis_tvalid && in_q.size() > 0 && $urandom_range(99) >= s_gap) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = in_q[0];
      end
      cmd_ready = (m_mode == 0) ? 1'b1 : 1'($urandom_range(1));
      case (m_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: m_axis_tready = ($urandom_range(99) < 70);
      endcase
      #1;
      hs_s = s_axis_tvalid && s_axis_tready;
      if (cmd_valid && cmd_ready) obs_cmd.push_back({cmd_op, cmd_len});
      if (m_axis_tvalid && m_axis_tready) obs_dat.push_back({m_axis_tlast, m_axis_tdata});
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_out   = {m_axis_tlast, m_axis_tdata};
      tick();
      if (hs_s) begin
        void'(in_q.pop_front());
        s_axis_tvalid = 1'b0;
      end
      cyc++;
    end
    s_axis_tvalid = 1'b0;
    cmd_ready     = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #3;
    n_checks++; if (s_axis_tready !== 1'b0) $display("FAIL rst_s_tready: got %b want 0", s_axis_tready); else n_pass++;
    n_checks++; if (cmd_valid !== 1'b0) $display("FAIL rst_cmd_valid: got %b want 0", cmd_valid); else n_pass++;
    n_checks++; if ({cmd_op, cmd_len} !== 24'h0) $display("FAIL rst_cmd_fields: got %h want 0", {cmd_op, cmd_len}); else n_pass++;
    n_checks++; if ({m_axis_tvalid, m_axis_tlast} !== 2'b00) $display("FAIL rst_m_vld_last: got %b want 00", {m_axis_tvalid, m_axis_tlast}); else n_pass++;
    n_checks++; if (m_axis_tdata !== 32'h0) $display("FAIL rst_m_tdata: got %h want 0", m_axis_tdata); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (err_count !== 8'h0) $display("FAIL rst_err: got %0d want 0", err_count); else n_pass++;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    resetn = 1'b1;
    tick();
    n_checks++; if (s_axis_tready !== 1'b1) $display("FAIL hunt_ready: got %b want 1", s_axis_tready); else n_pass++;
  endtask

  task automatic test_basic();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hA512_0003;
    cmd_ready     = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    n_checks++; if (s_axis_tready !== 1'b0) $display("FAIL basic_tready_drop: got %b want 0", s_axis_tready); else n_pass++;
    n_checks++; if ({cmd_valid, cmd_op, cmd_len} !== {1'b1, 8'h12, 16'd3}) $display("FAIL basic_cmd: got %h want %h", {cmd_valid, cmd_op, cmd_len}, {1'b1, 8'h12, 16'd3}); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else n_pass++;
    repeat (2) tick();
    n_checks++; if ({cmd_valid, cmd_op, cmd_len} !== {1'b1, 8'h12, 16'd3}) $display("FAIL basic_cmd_hold: got %h want %h", {cmd_valid, cmd_op, cmd_len}, {1'b1, 8'h12, 16'd3}); else n_pass++;
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    n_checks++; if ({cmd_valid, m_axis_tvalid} !== 2'b00) $display("FAIL basic_cmd_clear: got %b want 00", {cmd_valid, m_axis_tvalid}); else n_pass++;
    for (int k = 1; k <= 3; k++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'(k);
      tick();
      n_checks++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, (k == 3), 32'(k)})
        $display("FAIL basic_word%0d: got %h want %h", k, {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, (k == 3), 32'(k)});
      else n_pass++;
    end
    s_axis_tvalid = 1'b0;
    n_checks++; if (s_axis_tready !== 1'b0) $display("FAIL basic_no_extra_ready: got %b want 0", s_axis_tready); else n_pass++;
    tick();
    n_checks++; if ({busy, m_axis_tvalid, s_axis_tready} !== 3'b001) $display("FAIL basic_done: got %b want 001", {busy, m_axis_tvalid, s_axis_tready}); else n_pass++;
  endtask

  task automatic test_zero_len();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hA507_0000;
    cmd_ready     = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    n_checks++; if ({cmd_valid, cmd_op, cmd_len} !== {1'b1, 8'h07, 16'd0}) $display("FAIL zlen_cmd: got %h want %h", {cmd_valid, cmd_op, cmd_len}, {1'b1, 8'h07, 16'd0}); else n_pass++;
    tick();
    cmd_ready = 1'b0;
    n_checks++; if ({cmd_valid, busy, m_axis_tvalid, s_axis_tready} !== 4'b0001) $display("FAIL zlen_back_to_hunt: got %b want 0001", {cmd_valid, busy, m_axis_tvalid, s_axis_tready}); else n_pass++;
    in_q.delete();
    add_cmd(8'h44, 2);
    model_from_q();
    run_stream(0, 0, 0);
    n_checks++; if (timed_out) $display("FAIL zlen_follow_timeout: got timeout want completion"); else n_pass++;
    n_checks++; if (obs_cmd.size() != 1 || obs_cmd[0] !== exp_cmd[0]) $display("FAIL zlen_follow_cmd: got %0d cmds want 1 (%h)", obs_cmd.size(), exp_cmd[0]); else n_pass++;
    n_checks++; if (obs_dat.size() != 2 || obs_dat[0] !== exp_dat[0] || obs_dat[1] !== exp_dat[1]) $display("FAIL zlen_follow_data: got %0d words want 2", obs_dat.size()); else n_pass++;
  endtask

  task automatic test_errors();
    in_q.delete();
    in_q.push_back(32'h0000_0005);
    in_q.push_back(32'hA501_1001);
    add_cmd(8'h33, 2);
    model_from_q();
    run_stream(0, 0, 0);
    n_checks++; if (timed_out) $display("FAIL err_timeout: got timeout want completion"); else n_pass++;
    n_checks++; if (err_count !== 8'd2) $display("FAIL err_count: got %0d want 2", err_count); else n_pass++;
    n_checks++; if (obs_cmd.size() != exp_cmd.size()) $display("FAIL err_ncmd: got %0d want %0d", obs_cmd.size(), exp_cmd.size()); else n_pass++;
    for (int i = 0; i < exp_cmd.size(); i++) begin
      n_checks++; if (i >= obs_cmd.size() || obs_cmd[i] !== exp_cmd[i]) $display("FAIL err_cmd%0d: got %h want %h", i, (i < obs_cmd.size()) ? obs_cmd[i] : 24'hx, exp_cmd[i]); else n_pass++;
    end
    n_checks++; if (obs_dat.size() != exp_dat.size()) $display("FAIL err_nwords: got %0d want %0d", obs_dat.size(), exp_dat.size()); else n_pass++;
    for (int i = 0; i < exp_dat.size(); i++) begin
      n_checks++; if (i >= obs_dat.size() || obs_dat[i] !== exp_dat[i]) $display("FAIL err_word%0d: got %h want %h", i, (i < obs_dat.size()) ? obs_dat[i] : 33'hx, exp_dat[i]); else n_pass++;
    end
  endtask

  task automatic test_stall();
    in_q.delete();
    add_cmd(8'h5C, 4);
    add_cmd(8'h5D, 1);
    model_from_q();
    run_stream(1, 40, 0);
    n_checks++; if (timed_out) $display("FAIL stall_timeout: got timeout want completion"); else n_pass++;
    n_checks++; if (stall_viol != 0) $display("FAIL stall_stable: got %0d unstable cycles want 0", stall_viol); else n_pass++;
    n_checks++; if (obs_cmd.size() != exp_cmd.size()) $display("FAIL stall_ncmd: got %0d want %0d", obs_cmd.size(), exp_cmd.size()); else n_pass++;
    n_checks++; if (obs_dat.size() != exp_dat.size()) $display("FAIL stall_nwords: got %0d want %0d", obs_dat.size(), exp_dat.size()); else n_pass++;
    for (int i = 0; i < exp_dat.size(); i++) begin
      n_checks++; if (i >= obs_dat.size() || obs_dat[i] !== exp_dat[i]) $display("FAIL stall_word%0d: got %h want %h", i, (i < obs_dat.size()) ? obs_dat[i] : 33'hx, exp_dat[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    in_q.delete();
    add_cmd(8'h66, 5);
    run_stream(0, 0, 2);
    #2;
    resetn = 1'b0;
    #1;
    n_checks++; if (obs_dat.size() != 2 || obs_dat[0][32] !== 1'b0 || obs_dat[1][32] !== 1'b0) $display("FAIL rmid_partial: got %0d words want 2 without tlast", obs_dat.size()); else n_pass++;
    n_checks++; if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== 34'h0) $display("FAIL rmid_outputs: got %h want 0", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}); else n_pass++;
    n_checks++; if ({busy, cmd_valid, s_axis_tready, err_count} !== 11'h0) $display("FAIL rmid_ctrl: got %h want 0", {busy, cmd_valid, s_axis_tready, err_count}); else n_pass++;
    in_q.delete();
    model_err = 0;
    @(negedge aclk);
    resetn = 1'b1;
    tick();
    add_cmd(8'h77, 1);
    model_from_q();
    run_stream(0, 0, 0);
    n_checks++; if (timed_out) $display("FAIL rmid_timeout: got timeout want completion"); else n_pass++;
    n_checks++; if (obs_cmd.size() != 1 || obs_cmd[0] !== exp_cmd[0]) $display("FAIL rmid_cmd: got %0d cmds want 1 (%h)", obs_cmd.size(), exp_cmd[0]); else n_pass++;
    n_checks++; if (obs_dat.size() != 1 || obs_dat[0] !== exp_dat[0]) $display("FAIL rmid_word: got %0d words want 1 (%h)", obs_dat.size(), exp_dat[0]); else n_pass++;
  endtask

  task automatic test_random();
    in_q.delete();
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(3) == 0) add_bad();
      else add_cmd(8'($urandom), $urandom_range(6));
    end
    model_from_q();
    run_stream(2, 30, 0);
    n_checks++; if (timed_out) $display("FAIL rand_timeout: got timeout want completion"); else n_pass++;
    n_checks++; if (stall_viol != 0) $display("FAIL rand_stable: got %0d unstable cycles want 0", stall_viol); else n_pass++;
    n_checks++; if (err_count !== 8'(model_err > 255 ? 255 : model_err)) $display("FAIL rand_err: got %0d want %0d", err_count, model_err); else n_pass++;
    n_checks++; if (obs_cmd.size() != exp_cmd.size()) $display("FAIL rand_ncmd: got %0d want %0d", obs_cmd.size(), exp_cmd.size()); else n_pass++;
    for (int i = 0; i < exp_cmd.size(); i++) begin
      n_checks++; if (i >= obs_cmd.size() || obs_cmd[i] !== exp_cmd[i]) $display("FAIL rand_cmd%0d: got %h want %h", i, (i < obs_cmd.size()) ? obs_cmd[i] : 24'hx, exp_cmd[i]); else n_pass++;
    end
    n_checks++; if (obs_dat.size() != exp_dat.size()) $display("FAIL rand_nwords: got %0d want %0d", obs_dat.size(), exp_dat.size()); else n_pass++;
    for (int i = 0; i < exp_dat.size(); i++) begin
      n_checks++; if (i >= obs_dat.size() || obs_dat[i] !== exp_dat[i]) $display("FAIL rand_word%0d: got %h want %h", i, (i < obs_dat.size()) ? obs_dat[i] : 33'hx, exp_dat[i]); else n_pass++;
    end
  endtask

  task automatic test_saturate();
    in_q.delete();
    for (int n = 0; n < 300; n++) add_bad();
    model_from_q();
    run_stream(0, 0, 0);
    n_checks++; if (timed_out) $display("FAIL sat_timeout: got timeout want completion"); else n_pass++;
    n_checks++; if (err_count !== 8'(model_err > 255 ? 255 : model_err)) $display("FAIL sat_err: got %0d want %0d", err_count, (model_err > 255) ? 255 : model_err); else n_pass++;
    n_checks++; if (obs_cmd.size() != 0 || obs_dat.size() != 0) $display("FAIL sat_no_cmds: got %0d cmds %0d words want 0", obs_cmd.size(), obs_dat.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    model_err = 0;
    test_errors();
    test_stall();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
